// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. A single full-adder cell is
//               reused over WIDTH cycles, LSB first, with a carry flip-flop
//               linking the bit positions. The interface is a start/busy/done
//               handshake.
//               Optional macro SERIAL_ADD_SUB_EN adds subtract mode (sub)
//               and a signed-overflow flag (ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_carry_nxt;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

    // A new operation can only begin when no add is in flight.
    assign w_accept    = start & ((r_state == c_idle) | (r_state == c_done));
    assign w_last      = (r_cnt == c_last);

    // The single full-adder cell shared by all bit positions.
    assign w_s         = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_carry_nxt = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) |
                         (r_b_sr[0] & r_carry);

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so the carry-in is forced and cin is unused.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_run;
            c_run:   if (w_last) w_state_nxt = c_done;
            c_done:  w_state_nxt = start ? c_run : c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Operand shifters, carry, bit counter and result accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= w_c_load;
            r_cout  <= 1'b0;
        end else if (r_state == c_run) begin
            // Result enters at the MSB so bit i lands at sum[i] after WIDTH shifts.
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
            // Counter parks at the last position so it never wraps.
            if (!w_last) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_last) begin
                r_cout <= w_carry_nxt;
            end
        end
    end

`ifdef SERIAL_ADD_SUB_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_run) && w_last) begin
            r_ovf <= r_carry ^ w_carry_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == c_run);
    assign done = (r_state == c_done);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, cin;
    logic [7:0] a, b, sum;
    logic       busy, done, cout;

    logic       start2, cin2;
    logic [1:0] a2, b2, sum2;
    logic       busy2, done2, cout2;

`ifdef SERIAL_ADD_SUB_EN
    logic       sub, ovf, sub2, ovf2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
        .ovf   (ovf),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub2),
        .ovf   (ovf2),
`endif
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One full add on the 8-bit instance, checking handshake timing and result.
    task automatic do_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic [7:0] es, input logic ec);
        int n;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_sumclr"}, 32'(sum), 32'd0);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd8);
        check({tag, "_nobusy"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'({cout, sum}), 32'({ec, es}));
    endtask

    initial begin
        int n;
        int seen;
        int last_cyc;
        logic [7:0] ca, cb;
        logic       cc;
        logic [8:0] exp9;
        logic [1:0] da, db;
        logic       dc;
        logic [2:0] exp3;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0; sub2 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        reset = 1'b0;

        do_add("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        do_add("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_add("add00_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Start ignored while busy, then back-to-back start held in DONE.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (2) begin @(posedge clk); #1; n++; end
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1; n++;
        start = 1'b0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        check("ign_lat", 32'(n), 32'd8);
        check("ign_sum", 32'(sum), 32'h46);
        check("ign_cout", 32'(cout), 32'd0);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_busy", 32'(busy), 32'd1);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        check("b2b_lat", 32'(n), 32'd8);
        check("b2b_sum", 32'(sum), 32'h00);
        check("b2b_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADD_SUB_EN
        check("b2b_ovf", 32'(ovf), 32'd1);
`endif
        @(posedge clk); #1;

        // Reset in the middle of an add aborts it without a done pulse.
        a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort_nodone", 32'(seen), 32'd0);
        do_add("add01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        do_add("sub10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        check("sub10_01_ovf", 32'(ovf), 32'd0);
        do_add("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1);
        check("sub80_01_ovf", 32'(ovf), 32'd1);
        do_add("sub01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        check("sub01_02_ovf", 32'(ovf), 32'd0);
        sub = 1'b0;
`endif

        // Back-to-back stream on WIDTH=8 with start held high.
        ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
        a = ca; b = cb; cin = cc; start = 1'b1;
        @(posedge clk); #1;
        last_cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            exp9 = {1'b0, ca} + {1'b0, cb} + 9'(cc);
            ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
            a = ca; b = cb; cin = cc;
            n = 0;
            while (!done && n < 40) begin @(posedge clk); #1; n++; end
            check("rnd8_res", 32'({cout, sum}), 32'(exp9));
            if (i > 0) check("rnd8_gap", 32'(cyc - last_cyc), 32'd9);
            last_cyc = cyc;
            if (i == 999) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;

        // Back-to-back stream on WIDTH=2.
        da = 2'($urandom); db = 2'($urandom); dc = 1'($urandom);
        a2 = da; b2 = db; cin2 = dc; start2 = 1'b1;
        @(posedge clk); #1;
        last_cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            exp3 = {1'b0, da} + {1'b0, db} + 3'(dc);
            da = 2'($urandom); db = 2'($urandom); dc = 1'($urandom);
            a2 = da; b2 = db; cin2 = dc;
            n = 0;
            while (!done2 && n < 40) begin @(posedge clk); #1; n++; end
            check("rnd2_res", 32'({cout2, sum2}), 32'(exp3));
            if (i > 0) check("rnd2_gap", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (i == 999) start2 = 1'b0;
            @(posedge clk); #1;
        end
        start2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
